sha_hash_tx: RTL and testbench

SHA_HASH_TX -- requirements
Module: sha_hash_tx

---
 rtl/sha_hash_tx.sv | 145 ++++++++++++++
 tb/tb_sha_hash_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_hash_tx.sv
// Streams a captured SHA digest to a UART one byte at a time, MSB byte first.
// Define SHA_HASH_TX_HEX_ASCII_EN to send lowercase hex ASCII followed by CR/LF.
module sha_hash_tx #(
  parameter int unsigned HASH_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [HASH_WIDTH-1:0] hash_in,
  input  logic                  hash_valid,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CNT_W = 7;
  localparam int unsigned TO_W  = 2;
`ifdef SHA_HASH_TX_HEX_ASCII_EN
  localparam int unsigned NIBBLES   = HASH_WIDTH / 4;
  localparam int unsigned NUM_BYTES = NIBBLES + 2;
`else
  localparam int unsigned NUM_BYTES = HASH_WIDTH / 8;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_IDLE,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [HASH_WIDTH-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

`ifdef SHA_HASH_TX_HEX_ASCII_EN
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) hex_char = {4'h0, n} + 8'h30;
    else           hex_char = {4'h0, n} + 8'h57;
  endfunction
`endif

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    cnt_d      = cnt_q;
    to_cnt_d   = to_cnt_q;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    tx_start_d = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hash_valid) begin
          shadow_d = hash_in;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
`ifdef SHA_HASH_TX_HEX_ASCII_EN
        if (cnt_q < CNT_W'(NIBBLES)) begin
          tx_data_d = hex_char(shadow_q[HASH_WIDTH-1 -: 4]);
          shadow_d  = shadow_q << 4;
        end else if (cnt_q == CNT_W'(NIBBLES)) begin
          tx_data_d = 8'h0D;
        end else begin
          tx_data_d = 8'h0A;
        end
`else
        tx_data_d = shadow_q[HASH_WIDTH-1 -: 8];
        shadow_d  = shadow_q << 8;
`endif
        state_d = S_SEND;
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          to_cnt_d   = '0;
          state_d    = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        // A UART that never raises busy still advances after four cycles
        if (tx_busy || (to_cnt_q == TO_W'(3))) state_d = S_WAIT_IDLE;
        else                                   to_cnt_d = to_cnt_q + TO_W'(1);
      end
      S_WAIT_IDLE: begin
        if (!tx_busy) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(NUM_BYTES)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shadow_q   <= '0;
      cnt_q      <= '0;
      to_cnt_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      cnt_q      <= cnt_d;
      to_cnt_q   <= to_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sha_hash_tx.sv
// Directed bench for sha_hash_tx using the SHA-256("abc") digest and a small UART model.
module tb_sha_hash_tx;

  localparam int unsigned HW = 256;
  localparam logic [HW-1:0] DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [HW-1:0] OTHER =
    256'h0123456789abcdef0123456789abcdef0123456789abcdef0123456789abcdef;
`ifdef SHA_HASH_TX_HEX_ASCII_EN
  localparam int NEXP = 66;
`else
  localparam int NEXP = 32;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [HW-1:0] hash_in;
  logic          hash_valid;
  logic          tx_busy;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  // UART model mode: 0 = acks for 10 cycles, 1 = never acks, 2 = tx_busy driven by the test
  int mode = 1;
  int busy_left = 0;
  logic prev_start = 1'b0;
  int consec_viol = 0;
  int busy_viol = 0;
  int done_cnt = 0;
  logic [7:0] got[$];
  logic [7:0] exp_b[NEXP];

  sha_hash_tx #(.HASH_WIDTH(HW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hash_in   (hash_in),
    .hash_valid(hash_valid),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Monitor and UART model, evaluated on the falling edge
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      if (prev_start) consec_viol++;
      if (tx_busy) busy_viol++;
      got.push_back(tx_data);
    end
    prev_start = tx_start;
    if (done === 1'b1) done_cnt++;
    if (mode == 0) begin
      if (tx_start === 1'b1) begin
        tx_busy = 1'b1;
        busy_left = 10;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end
    end else if (mode == 1) begin
      tx_busy = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c = 0;
    while (done !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int c = 0;
    while (got.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(got.size() >= n), 32'd1);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_len"}, 32'(got.size()), 32'(NEXP));
    for (int i = 0; i < NEXP; i++)
      if (i < got.size()) chk($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp_b[i]));
  endtask

  task automatic capture(input logic [HW-1:0] v);
    @(negedge clk);
    hash_in = v;
    hash_valid = 1'b1;
    @(negedge clk);
    hash_valid = 1'b0;
  endtask

  initial begin
    logic [HW-1:0] dg;
    logic [3:0] nib;
    int d0;
    dg = DIGEST;
`ifdef SHA_HASH_TX_HEX_ASCII_EN
    for (int i = 0; i < 64; i++) begin
      nib = dg[HW-1-4*i -: 4];
      exp_b[i] = (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h61 + 8'(nib) - 8'd10);
    end
    exp_b[64] = 8'h0D;
    exp_b[65] = 8'h0A;
`else
    nib = 4'h0;
    for (int i = 0; i < 32; i++) exp_b[i] = dg[HW-1-8*i -: 8];
`endif

    // Reset state
    rst_n = 1'b0; hash_in = '0; hash_valid = 1'b0; tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Raw stream with 10-cycle UART busy, plus capture latency
    mode = 0;
    got.delete();
    d0 = done_cnt;
    hash_in = DIGEST; hash_valid = 1'b1;
    @(negedge clk);
    hash_valid = 1'b0;
    chk("lat_busy", 32'(busy), 32'd1);
    chk("lat_start_c1", 32'(tx_start), 32'd0);
    @(negedge clk);
    chk("lat_start_c2", 32'(tx_start), 32'd0);
    @(negedge clk);
    chk("lat_start_c3", 32'(tx_start), 32'd1);
    chk("first_byte", 32'(tx_data), 32'(exp_b[0]));
    wait_done("t1_done", 3000);
    chk("t1_busy_at_done", 32'(busy), 32'd0);
    check_stream("t1");
`ifndef SHA_HASH_TX_HEX_ASCII_EN
    if (got.size() == 32) begin
      chk("t1_byte0_ba", 32'(got[0]), 32'hBA);
      chk("t1_byte31_ad", 32'(got[31]), 32'hAD);
    end
`endif

    // hash_valid during the done pulse is dropped; one cycle later it captures
    got.delete();
    hash_in = DIGEST; hash_valid = 1'b1;
    @(negedge clk);
    chk("done_cycle_ignored", 32'(busy), 32'd0);
    chk("t1_one_done", 32'(done_cnt - d0), 32'd1);
    @(negedge clk);
    hash_valid = 1'b0;
    chk("capture_after_done", 32'(busy), 32'd1);

    // Re-pulse with different digest during byte 5 is ignored
    d0 = done_cnt;
    wait_bytes("t2_reach5", 5, 500);
    hash_in = OTHER; hash_valid = 1'b1;
    @(negedge clk);
    hash_valid = 1'b0;
    wait_done("t2_done", 3000);
    check_stream("t2");
    repeat (30) @(negedge clk);
    chk("t2_one_done", 32'(done_cnt - d0), 32'd1);
    chk("t2_idle_busy", 32'(busy), 32'd0);

    // UART never acks: each byte advances by timeout
    mode = 1;
    @(negedge clk);
    got.delete();
    d0 = done_cnt;
    capture(DIGEST);
    wait_done("t3_done", 3000);
    check_stream("t3");
    @(negedge clk);
    chk("t3_one_done", 32'(done_cnt - d0), 32'd1);

    // Reset during byte 10 aborts; new capture restarts from byte 0
    mode = 0;
    got.delete();
    capture(DIGEST);
    wait_bytes("t4_reach10", 10, 1000);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t4_rst_tx_start", 32'(tx_start), 32'd0);
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_done", 32'(done), 32'd0);
    got.delete();
    repeat (20) @(negedge clk);
    chk("t4_no_resume", 32'(got.size()), 32'd0);
    d0 = done_cnt;
    capture(DIGEST);
    wait_done("t4_done", 3000);
    check_stream("t4");
    @(negedge clk);
    chk("t4_one_done", 32'(done_cnt - d0), 32'd1);

    // UART busy at capture for 20 cycles delays the first tx_start
    mode = 2;
    tx_busy = 1'b1;
    got.delete();
    capture(DIGEST);
    repeat (19) @(negedge clk);
    chk("t5_held", 32'(got.size()), 32'd0);
    chk("t5_busy", 32'(busy), 32'd1);
    tx_busy = 1'b0;
    mode = 0;
    @(negedge clk);
    chk("t5_first_start", 32'(tx_start), 32'd1);
    wait_done("t5_done", 3000);
    check_stream("t5");

    chk("no_consecutive_start", 32'(consec_viol), 32'd0);
    chk("no_start_while_busy", 32'(busy_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
